// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-256 key-schedule constants, round constants and FSM
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NK256 = 8;
    localparam int NR256 = 14;

    // Entry 0 is unused; the schedule only ever indexes 1..7.
    localparam logic [7:0][7:0] RCON = {8'h40, 8'h20, 8'h10, 8'h08,
                                        8'h04, 8'h02, 8'h01, 8'h00};

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes256_dec_key_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : aes256_dec_key_sched_if
// Purpose  : Key-load request and round-key stream of the decrypt key
//            scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface aes256_dec_key_sched_if;

    logic         key_load;
    logic [255:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last;

    modport master (
        output key_load, key, rk_ready,
        input  busy, rk_valid, rk, rk_idx, rk_last
    );

    modport slave (
        input  key_load, key, rk_ready,
        output busy, rk_valid, rk, rk_idx, rk_last
    );

endinterface
`default_nettype wire

// File: rtl/aes_key_step256.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_step256
// Purpose  : One AES-256 key-schedule block step, forward (dir=0) or inverse
//            (dir=1); both directions share the same eight S-boxes.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_step256
    import aes_pkg::*;
(
    input  wire logic [255:0] blk,
    input  wire logic [7:0]   rcon,
    input  wire logic         dir,
    output logic      [255:0] blk_out
);

    logic [31:0] w_in [8];
    logic [31:0] w_sub_a_in;
    logic [31:0] w_sub_a;
    logic [31:0] w_sub_b_in;
    logic [31:0] w_sub_b;
    logic [31:0] w_rcon_word;
    logic [31:0] w_f0, w_f1, w_f2, w_f3, w_f4, w_f5, w_f6, w_f7;
    logic [31:0] w_p0, w_p1, w_p2, w_p3, w_p4, w_p5, w_p6, w_p7;

    for (genvar i = 0; i < 8; i++) begin : g_word
        assign w_in[i] = blk[255 - 32 * i -: 32];
    end

    // Bank A feeds word 0 (from w7 forward, from rebuilt p7 inverse);
    // bank B feeds word 4 (from new w3 forward, from current w3 inverse).
    assign w_sub_a_in = rot_word(dir ? (w_in[7] ^ w_in[6]) : w_in[7]);
    assign w_sub_b_in = dir ? w_in[3] : w_f3;

    for (genvar j = 0; j < 4; j++) begin : g_sbox
        aes_sbox u_sbox_a (.din(w_sub_a_in[8 * j +: 8]), .dout(w_sub_a[8 * j +: 8]));
        aes_sbox u_sbox_b (.din(w_sub_b_in[8 * j +: 8]), .dout(w_sub_b[8 * j +: 8]));
    end

    assign w_rcon_word = {rcon, 24'h000000};

    assign w_f0 = w_in[0] ^ w_sub_a ^ w_rcon_word;
    assign w_f1 = w_in[1] ^ w_f0;
    assign w_f2 = w_in[2] ^ w_f1;
    assign w_f3 = w_in[3] ^ w_f2;
    assign w_f4 = w_in[4] ^ w_sub_b;
    assign w_f5 = w_in[5] ^ w_f4;
    assign w_f6 = w_in[6] ^ w_f5;
    assign w_f7 = w_in[7] ^ w_f6;

    assign w_p7 = w_in[7] ^ w_in[6];
    assign w_p6 = w_in[6] ^ w_in[5];
    assign w_p5 = w_in[5] ^ w_in[4];
    assign w_p4 = w_in[4] ^ w_sub_b;
    assign w_p3 = w_in[3] ^ w_in[2];
    assign w_p2 = w_in[2] ^ w_in[1];
    assign w_p1 = w_in[1] ^ w_in[0];
    assign w_p0 = w_in[0] ^ w_sub_a ^ w_rcon_word;

    assign blk_out = dir ? {w_p0, w_p1, w_p2, w_p3, w_p4, w_p5, w_p6, w_p7}
                         : {w_f0, w_f1, w_f2, w_f3, w_f4, w_f5, w_f6, w_f7};

endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Purpose  : Combinational AES forward S-box lookup (one byte).
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  wire logic [7:0] din,
    output logic      [7:0] dout
);

    // Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = c_sbox[2047 - 8 * int'(din) -: 8];

endmodule
`default_nettype wire

// File: rtl/aes256_dec_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes256_dec_key_sched
// Purpose  : AES-256 decrypt round-key generator: expands forward to the last
//            key block, then streams round keys 14..0 walking backwards.
// Revision : 1.0 - initial release
// ============================================================================
module aes256_dec_key_sched
    import aes_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst_n,
    aes256_dec_key_sched_if.slave   bus
);

    state_t       r_state;
    logic [255:0] r_s;
    logic [2:0]   r_b;
    logic [3:0]   r_idx;

    logic [2:0]   w_b_inc;
    logic         w_inverse;
    logic [7:0]   w_rcon;
    logic [255:0] w_step;

    assign w_b_inc   = r_b + 3'd1;
    assign w_inverse = (r_state == ST_STREAM);
    assign w_rcon    = w_inverse ? RCON[r_b] : RCON[w_b_inc];

    aes_key_step256 u_step (
        .blk     (r_s),
        .rcon    (w_rcon),
        .dir     (w_inverse),
        .blk_out (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.key_load) begin
                        r_s     <= bus.key;
                        r_b     <= 3'd0;
                        r_state <= ST_EXPAND;
                    end
                end
                ST_EXPAND: begin
                    r_s <= w_step;
                    r_b <= w_b_inc;
                    if (r_b == 3'd6) begin
                        r_state <= ST_STREAM;
                        r_idx   <= 4'(NR256);
                    end
                end
                ST_STREAM: begin
                    if (bus.rk_ready) begin
                        if (r_idx == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx - 4'd1;
                            // Leaving the high half means the previous block is needed next.
                            if (!r_idx[0]) begin
                                r_s <= w_step;
                                r_b <= r_b - 3'd1;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.rk_valid = (r_state == ST_STREAM);
    assign bus.rk       = r_idx[0] ? r_s[127:0] : r_s[255:128];
    assign bus.rk_idx   = r_idx;
    assign bus.rk_last  = (r_state == ST_STREAM) && (r_idx == 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_aes256_dec_key_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes256_dec_key_sched
// Purpose  : Scoreboard bench for the AES-256 decrypt key scheduler against a
//            FIPS-197 style key-expansion model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes256_dec_key_sched;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
        logic         last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    aes256_dec_key_sched_if bus ();

    aes256_dec_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           checks = 0;
    int           passed = 0;
    beat_t        exp_q[$];
    logic [7:0]   sb [256];
    logic [31:0]  wm [60];
    logic [127:0] cap [15];
    logic         cap_last0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] k);
        logic [7:0]  rc;
        logic [31:0] t;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) wm[i] = k[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = wm[i - 1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            wm[i] = wm[i - 8] ^ t;
        end
    endtask

    function automatic logic [127:0] round_key(input int r);
        return {wm[4 * r], wm[4 * r + 1], wm[4 * r + 2], wm[4 * r + 3]};
    endfunction

    task automatic push_expected(input logic [255:0] k);
        beat_t b;
        expand(k);
        for (int r = 14; r >= 0; r--) begin
            b.idx  = 4'(r);
            b.rk   = round_key(r);
            b.last = (r == 0);
            exp_q.push_back(b);
        end
        for (int r = 0; r < 15; r++) cap[r] = '0;
        cap_last0 = 1'b0;
    endtask

    // Monitor: compares every transfer and checks stability while stalled.
    initial begin : monitor
        logic         stalled;
        logic [132:0] held;
        beat_t        e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("valid held in stall", 256'(bus.rk_valid), 256'(1));
                    if (bus.rk_valid)
                        chk("outputs held in stall", 256'({bus.rk, bus.rk_idx, bus.rk_last}), 256'(held));
                end
                stalled = 1'b0;
                if (bus.rk_valid) begin
                    if (bus.rk_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected beat", 256'(bus.rk_idx), 256'hdead);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("beat idx %0d", e.idx),
                                256'({bus.rk, bus.rk_idx, bus.rk_last}),
                                256'({e.rk, e.idx, e.last}));
                            cap[bus.rk_idx] = bus.rk;
                            if (bus.rk_idx == 4'd0) cap_last0 = bus.rk_last;
                        end
                    end else begin
                        stalled = 1'b1;
                        held    = {bus.rk, bus.rk_idx, bus.rk_last};
                    end
                end
            end
        end
    end

    // mode 0: rk_ready held high and timing checked; mode 1: random rk_ready.
    task automatic run_session(input logic [255:0] k, input int mode, input bit poke);
        int n;
        push_expected(k);
        @(posedge clk); #1;
        bus.key      = k;
        bus.key_load = 1'b1;
        bus.rk_ready = (mode == 0);
        @(posedge clk); #1;
        bus.key_load = 1'b0;
        n = 1;
        chk("busy after load", 256'(bus.busy), 256'(1));
        while (!bus.rk_valid && n < 40) begin
            if (mode != 0) bus.rk_ready = 1'($urandom_range(0, 1));
            bus.key_load = poke && (n == 3);
            if (poke && n == 3) bus.key = ~k;
            @(posedge clk); #1;
            n++;
        end
        if (mode == 0) chk("load latency", 256'(n), 256'(8));
        while (bus.busy && n < 400) begin
            bus.rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.key_load = poke && ((bus.rk_idx == 4'd7) || (bus.rk_last && bus.rk_ready));
            @(posedge clk); #1;
            n++;
        end
        bus.key_load = 1'b0;
        bus.key      = k;
        if (mode == 0) chk("load to idle cycles", 256'(n), 256'(23));
        chk("stream finished", 256'({bus.busy, bus.rk_valid}), 256'(0));
        chk("all beats delivered", 256'(exp_q.size()), 256'(0));
        exp_q.delete();
        @(posedge clk); #1;
        chk("stays idle after final accept", 256'({bus.busy, bus.rk_valid}), 256'(0));
    endtask

    task automatic reset_mid(input logic [255:0] k, input bit in_stream);
        int n;
        push_expected(k);
        @(posedge clk); #1;
        bus.key      = k;
        bus.key_load = 1'b1;
        bus.rk_ready = 1'b1;
        @(posedge clk); #1;
        bus.key_load = 1'b0;
        n = 0;
        if (!in_stream) begin
            repeat (4) begin @(posedge clk); #1; end
            chk("busy before expand reset", 256'({bus.busy, bus.rk_valid}), 256'(2));
        end else begin
            while (!(bus.rk_valid && bus.rk_idx == 4'd8) && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            chk("reached idx 8 before reset", 256'(n < 60), 256'(1));
        end
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("outputs zero in reset",
            256'({bus.busy, bus.rk_valid, bus.rk, bus.rk_idx, bus.rk_last}), 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin @(posedge clk); end
        #1;
        chk("idle after reset release", 256'({bus.busy, bus.rk_valid, bus.rk}), 256'(0));
    endtask

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_SEQ =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin : driver
        logic [255:0] k;
        bus.key_load = 1'b0;
        bus.key      = '0;
        bus.rk_ready = 1'b0;
        build_sbox();
        #1 rst_n = 1'b0;
        #2;
        chk("reset outputs",
            256'({bus.busy, bus.rk_valid, bus.rk, bus.rk_idx, bus.rk_last}), 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run_session(KEY_A3, 0, 1'b0);
        chk("A.3 idx 14", 256'(cap[14]), 256'(128'hfe4890d1e6188d0b046df344706c631e));
        chk("A.3 idx 0", 256'(cap[0]), 256'(128'h603deb1015ca71be2b73aef0857d7781));
        chk("A.3 rk_last", 256'(cap_last0), 256'(1));

        run_session(KEY_SEQ, 0, 1'b0);
        chk("seq idx 14", 256'(cap[14]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));
        chk("seq idx 1", 256'(cap[1]), 256'(128'h101112131415161718191a1b1c1d1e1f));
        chk("seq idx 0", 256'(cap[0]), 256'(128'h000102030405060708090a0b0c0d0e0f));

        run_session(KEY_A3, 1, 1'b0);
        run_session(KEY_SEQ, 1, 1'b1);
        run_session(KEY_A3, 0, 1'b1);

        reset_mid(KEY_A3, 1'b0);
        run_session(KEY_A3, 0, 1'b0);
        reset_mid(KEY_SEQ, 1'b1);
        run_session(KEY_SEQ, 0, 1'b0);
        chk("reload idx 14", 256'(cap[14]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));

        repeat (5) begin
            for (int i = 0; i < 8; i++) k[255 - 32 * i -: 32] = $urandom();
            run_session(k, 1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
